// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and encodings for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF requester, MEM requester and memory-side handshakes.
//   master : arbiter view (takes requests, drives memory bus, valids, stalls)
//   slave  : environment view (requesters and memory)
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  // fetch requester
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifFlush;
  logic [DATA_W-1:0] ifData;
  logic              ifValid;
  // data requester
  logic              dReq;
  logic              dWe;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWData;
  logic [DATA_W-1:0] dRData;
  logic              dValid;
  // memory port
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;
  logic              memAck;
  // pipeline holds
  logic              stallIf;
  logic              stallMem;

  modport master (
    input  ifReq, ifAddr, ifFlush, dReq, dWe, dAddr, dWData, memRData, memAck,
    output ifData, ifValid, dRData, dValid, memReq, memWe, memAddr, memWData,
           stallIf, stallMem
  );

  modport slave (
    output ifReq, ifAddr, ifFlush, dReq, dWe, dAddr, dWData, memRData, memAck,
    input  ifData, ifValid, dRData, dValid, memReq, memWe, memAddr, memWData,
           stallIf, stallMem
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : master modport carrying the IF, D and memory handshakes and stalls
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              cancel_q, cancel_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_valid_q, d_valid_d;

  logic              if_live, d_live, if_ok;
  logic              grant_if, grant_d;

  // A request still high during its own valid pulse is already served;
  // masking it prevents a duplicate grant on the edge that ends the pulse.
  assign if_live = bus.ifReq & ~if_valid_q;
  assign d_live  = bus.dReq & ~d_valid_q;
  assign if_ok   = if_live & ~bus.ifFlush;

  // Arbitration, transaction tracking and response capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cancel_d     = cancel_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_data_d    = if_data_q;
    if_valid_d   = 1'b0;
    d_rdata_d    = d_rdata_q;
    d_valid_d    = 1'b0;
    grant_if     = 1'b0;
    grant_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // On a tie D wins only if IF had the last grant, so the two alternate.
        grant_d  = d_live & (~if_ok | (last_grant_q == GNT_IF));
        grant_if = if_ok & ~grant_d;
        if (grant_d) begin
          state_d      = ST_DATA;
          last_grant_d = GNT_D;
          mem_req_d    = 1'b1;
          mem_we_d     = bus.dWe;
          mem_addr_d   = bus.dAddr;
          mem_wdata_d  = bus.dWData;
        end else if (grant_if) begin
          state_d      = ST_FETCH;
          last_grant_d = GNT_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.ifAddr;
        end
      end
      ST_FETCH: begin
        if (bus.memAck) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          cancel_d  = 1'b0;
          if (!(cancel_q || bus.ifFlush)) begin
            if_data_d  = bus.memRData;
            if_valid_d = 1'b1;
          end
        end else if (bus.ifFlush) begin
          cancel_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (bus.memAck) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          d_valid_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = bus.memRData;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        cancel_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_IF;
      cancel_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_data_q    <= '0;
      if_valid_q   <= 1'b0;
      d_rdata_q    <= '0;
      d_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cancel_q     <= cancel_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_data_q    <= if_data_d;
      if_valid_q   <= if_valid_d;
      d_rdata_q    <= d_rdata_d;
      d_valid_q    <= d_valid_d;
    end
  end

  assign bus.memReq   = mem_req_q;
  assign bus.memWe    = mem_we_q;
  assign bus.memAddr  = mem_addr_q;
  assign bus.memWData = mem_wdata_q;
  assign bus.ifData   = if_data_q;
  assign bus.ifValid  = if_valid_q;
  assign bus.dRData   = d_rdata_q;
  assign bus.dValid   = d_valid_q;

  // Stalls release in the valid-pulse cycle so the stage advances.
  assign bus.stallIf  = if_live;
  assign bus.stallMem = d_live;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected responses,
// a negedge monitor pops and compares, a memory model answers with random latency.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW = DEF_ADDR_W;
  localparam int unsigned DW = DEF_DATA_W;

  typedef struct {
    logic        st;
    logic [31:0] data;
  } d_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } tx_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] if_q[$];
  d_exp_t      d_q[$];
  tx_t         log_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dmem    [logic [31:0]];
  logic [31:0] last_if, last_dr;
  bit          log_en = 1'b0;
  bit          spur_en = 1'b0;
  int          lat_cfg = 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    ref_mem[a] = v;
    dmem[a]    = v;
  endtask

  task automatic check_log(input string name, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input bit chk_wd);
    tx_t t;
    if (log_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no memory transaction seen, expected addr %08h", name, a);
    end else begin
      t = log_q.pop_front();
      check({name, "_addr"}, t.addr, a);
      check({name, "_we"}, 32'(t.we), 32'(we));
      if (chk_wd) check({name, "_wdata"}, t.wdata, wd);
    end
  endtask

  // Memory model: ack after a latency of 1..N cycles of memReq, checks command stability.
  initial begin
    int  cnt;
    int  lat;
    tx_t cur;
    cnt = 0;
    lat = 1;
    cur = '{addr: 32'h0, we: 1'b0, wdata: 32'h0};
    bus.memAck   = 1'b0;
    bus.memRData = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.memAck   = 1'b0;
      bus.memRData = DW'($urandom);
      if (!reset || !bus.memReq) begin
        cnt = 0;
        if (reset && spur_en && ($urandom_range(0, 7) == 0)) bus.memAck = 1'b1;
      end else begin
        cnt++;
        if (cnt == 1) begin
          cur.addr  = bus.memAddr;
          cur.we    = bus.memWe;
          cur.wdata = bus.memWData;
          lat = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
          if (log_en) log_q.push_back(cur);
        end else begin
          check("memAddr_stable", bus.memAddr, cur.addr);
          check("memWe_stable", 32'(bus.memWe), 32'(cur.we));
          check("memWData_stable", bus.memWData, cur.wdata);
        end
        if (cnt == lat) begin
          bus.memAck = 1'b1;
          if (cur.we) dmem[cur.addr] = cur.wdata;
          else bus.memRData = dmem.exists(cur.addr) ? dmem[cur.addr] : init_word(cur.addr);
        end
      end
    end
  end

  // Monitor: compare every valid pulse against the scoreboard, and the stalls.
  always @(negedge clock) begin
    logic [31:0] e;
    d_exp_t      de;
    if (!reset) begin
      last_if = 32'h0;
      last_dr = 32'h0;
    end else begin
      if (bus.ifValid) begin
        check("stallIf_in_valid", 32'(bus.stallIf), 32'h0);
        if (if_q.size() == 0) begin
          check("ifValid_unexpected", 32'(bus.ifValid), 32'h0);
        end else begin
          e = if_q.pop_front();
          check("ifData", bus.ifData, e);
          last_if = e;
        end
      end else begin
        check("stallIf", 32'(bus.stallIf), 32'(bus.ifReq));
      end
      if (bus.dValid) begin
        check("stallMem_in_valid", 32'(bus.stallMem), 32'h0);
        if (d_q.size() == 0) begin
          check("dValid_unexpected", 32'(bus.dValid), 32'h0);
        end else begin
          de = d_q.pop_front();
          if (de.st) begin
            check("dRData_hold_on_store", bus.dRData, last_dr);
          end else begin
            check("dRData", bus.dRData, de.data);
            last_dr = de.data;
          end
        end
      end else begin
        check("stallMem", 32'(bus.stallMem), 32'(bus.dReq));
      end
    end
  end

  // Issue one IF and/or one D request, hold each until its valid, optionally flush IF.
  // Called at posedge+1; returns cycle numbers of the valid pulses (0 if none).
  task automatic run_reqs(input bit want_if, input logic [31:0] ia,
                          input bit want_d, input bit we, input logic [31:0] da,
                          input logic [31:0] wd, input int flush_at,
                          output int if_cyc, output int d_cyc);
    bit if_pend, d_pend, if_fin, d_fin;
    int n;
    if_pend = want_if; d_pend = want_d; if_fin = 1'b0; d_fin = 1'b0;
    n = 0; if_cyc = 0; d_cyc = 0;
    if (want_if) begin
      bus.ifAddr = ia;
      bus.ifReq  = 1'b1;
      if_q.push_back(ref_read(ia));
    end
    if (want_d) begin
      bus.dAddr  = da;
      bus.dWe    = we;
      bus.dWData = wd;
      bus.dReq   = 1'b1;
      if (we) begin
        ref_mem[da] = wd;
        d_q.push_back(d_exp_t'{st: 1'b1, data: 32'h0});
      end else begin
        d_q.push_back(d_exp_t'{st: 1'b0, data: ref_read(da)});
      end
    end
    while ((if_pend || d_pend) && n < 100) begin
      @(posedge clock);
      #1;
      n++;
      bus.ifFlush = 1'b0;
      if (if_fin) begin bus.ifReq = 1'b0; if_fin = 1'b0; end
      if (d_fin)  begin bus.dReq  = 1'b0; d_fin  = 1'b0; end
      if (if_pend && bus.ifValid) begin
        if_pend = 1'b0; if_fin = 1'b1; if_cyc = n;
      end else if (if_pend && n == flush_at) begin
        bus.ifFlush = 1'b1;
        bus.ifReq   = 1'b0;
        if_pend     = 1'b0;
        void'(if_q.pop_back());
      end
      if (d_pend && bus.dValid) begin
        d_pend = 1'b0; d_fin = 1'b1; d_cyc = n;
      end
    end
    if (if_pend || d_pend) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: if_pending=%0d d_pending=%0d after %0d cycles, required none",
               if_pend, d_pend, n);
      bus.ifReq = 1'b0;
      bus.dReq  = 1'b0;
      if_q.delete();
      d_q.delete();
    end
    @(posedge clock);
    #1;
    bus.ifFlush = 1'b0;
    if (if_fin) bus.ifReq = 1'b0;
    if (d_fin)  bus.dReq  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ic, dc;
    reset       = 1'b0;
    bus.ifReq   = 1'b0;
    bus.ifAddr  = '0;
    bus.ifFlush = 1'b0;
    bus.dReq    = 1'b0;
    bus.dWe     = 1'b0;
    bus.dAddr   = '0;
    bus.dWData  = '0;
    preload(32'h40, 32'h8C220004);

    // Reset for two cycles, then all outputs idle.
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_memReq", 32'(bus.memReq), 32'h0);
    check("rst_memWe", 32'(bus.memWe), 32'h0);
    check("rst_memAddr", bus.memAddr, 32'h0);
    check("rst_memWData", bus.memWData, 32'h0);
    check("rst_ifData", bus.ifData, 32'h0);
    check("rst_dRData", bus.dRData, 32'h0);
    check("rst_ifValid", 32'(bus.ifValid), 32'h0);
    check("rst_dValid", 32'(bus.dValid), 32'h0);

    // Fetch only, ack in third cycle: valid in cycle 4.
    log_en  = 1'b1;
    lat_cfg = 3;
    @(posedge clock); #1;
    run_reqs(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 0, ic, dc);
    check("fetch_valid_cycle", 32'(ic), 32'd4);
    check_log("fetch_tx", 32'h40, 1'b0, 32'h0, 1'b0);

    // Tie after an IF grant: D first, then IF; next tie goes to D again.
    lat_cfg = 2;
    run_reqs(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0, 0, ic, dc);
    check_log("tie1_first_D", 32'h100, 1'b0, 32'h0, 1'b0);
    check_log("tie1_then_IF", 32'h44, 1'b0, 32'h0, 1'b0);
    check("tie1_order", 32'(dc < ic), 32'h1);
    run_reqs(1'b1, 32'h4C, 1'b1, 1'b0, 32'h104, 32'h0, 0, ic, dc);
    check_log("tie2_first_D", 32'h104, 1'b0, 32'h0, 1'b0);
    check_log("tie2_then_IF", 32'h4C, 1'b0, 32'h0, 1'b0);

    // Store with minimum latency, then load it back.
    lat_cfg = 1;
    run_reqs(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 0, ic, dc);
    check("store_valid_cycle", 32'(dc), 32'd2);
    check_log("store_tx", 32'h200, 1'b1, 32'hDEADBEEF, 1'b1);
    run_reqs(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 0, ic, dc);
    check_log("load_back_tx", 32'h200, 1'b0, 32'h0, 1'b0);

    // Flush in cycle 2 of a fetch acked in cycle 4: no valid, ifData held.
    lat_cfg = 4;
    run_reqs(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 2, ic, dc);
    check("flush_no_valid", 32'(ic), 32'h0);
    repeat (5) @(negedge clock);
    check("flush_idle_memReq", 32'(bus.memReq), 32'h0);
    check("flush_ifData_held", bus.ifData, last_if);
    check_log("flush_tx", 32'h48, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of a data transaction.
    lat_cfg = 10;
    @(posedge clock); #1;
    bus.dAddr = 32'h108;
    bus.dWe   = 1'b0;
    bus.dReq  = 1'b1;
    d_q.push_back(d_exp_t'{st: 1'b0, data: ref_read(32'h108)});
    @(posedge clock); #1;
    check("midrst_memReq_before", 32'(bus.memReq), 32'h1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("midrst_memReq_async", 32'(bus.memReq), 32'h0);
    check("midrst_dValid", 32'(bus.dValid), 32'h0);
    bus.dReq = 1'b0;
    void'(d_q.pop_back());
    check_log("midrst_tx", 32'h108, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_after_dRData", bus.dRData, 32'h0);
    check("midrst_after_memWe", 32'(bus.memWe), 32'h0);
    lat_cfg = 2;
    @(posedge clock); #1;
    run_reqs(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, 0, ic, dc);
    check("post_rst_fetch_cycle", 32'(ic), 32'd3);
    check_log("post_rst_fetch_tx", 32'h50, 1'b0, 32'h0, 1'b0);

    // Randomized traffic: random latency, ties, flushes and stray acks.
    log_en  = 1'b0;
    log_q.delete();
    lat_cfg = 0;
    spur_en = 1'b1;
    for (int it = 0; it < 250; it++) begin
      bit          wi, wd, we;
      int          fa, gap;
      logic [31:0] ia, da, wdat;
      wi   = 1'($urandom_range(0, 1));
      wd   = wi ? 1'($urandom_range(0, 1)) : 1'b1;
      we   = 1'($urandom_range(0, 1));
      ia   = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      da   = 32'h100 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      wdat = 32'($urandom);
      fa   = (wi && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      gap  = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clock); #1; end
      run_reqs(wi, ia, wd, we, da, wdat, fa, ic, dc);
    end
    spur_en = 1'b0;
    repeat (10) @(negedge clock);
    check("if_q_drained", 32'(if_q.size()), 32'h0);
    check("d_q_drained", 32'(d_q.size()), 32'h0);
    check("final_memReq", 32'(bus.memReq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the instruction-fetch stage (IF) and the load/store stage (MEM) of the pipelined datapath.
- Grants the port to one requester at a time and drives the memory request/acknowledge handshake.
- Returns read data to the granted requester.
- Generates stall signals so IF and MEM hold while their access is outstanding.
- Sits beside the hazard unit: its stall outputs are ORed into the PC-hold and pipeline-hold logic at the top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- ifReq  input  1  fetch request; held high until ifValid.
- ifAddr  input  ADDR_W  fetch address; stable while ifReq high.
- ifFlush  input  1  branch taken: discard any pending or in-flight fetch.
- ifData  output  DATA_W  fetched instruction.
- ifValid  output  1  one-cycle pulse, ifData valid.
- dReq  input  1  data request; held high until dValid.
- dWe  input  1  1 = store, 0 = load; stable while dReq high.
- dAddr  input  ADDR_W  data address.
- dWData  input  DATA_W  store data.
- dRData  output  DATA_W  load data.
- dValid  output  1  one-cycle pulse, access complete (load or store).
- memReq  output  1  memory request; high for the whole transaction.
- memWe  output  1  write enable to memory.
- memAddr  output  ADDR_W  registered address.
- memWData  output  DATA_W  registered write data.
- memRData  input  DATA_W  memory read data; valid when memAck high.
- memAck  input  1  one-cycle completion pulse from memory; latency 1..N cycles.
- stallIf  output  1  hold PC and IF/ID.
- stallMem  output  1  hold EX/MEM and earlier stages.

Behaviour:
- States:
  - IDLE: no transaction in flight.
  - FETCH: fetch transaction in flight.
  - DATA: data transaction in flight.
- State register lastGrant (0 = IF, 1 = D) records the last granted requester.
- Reset (reset low, asynchronous):
  - state = IDLE, lastGrant = IF.
  - memReq, memWe, ifValid, dValid = 0.
  - memAddr, memWData, ifData, dRData = 0.
- IDLE, at the clock edge:
  - If only dReq: go to DATA; latch dAddr, dWe, dWData into memAddr, memWe, memWData.
  - If only ifReq and not ifFlush: go to FETCH; latch ifAddr; memWe = 0.
  - If both requested: grant D when lastGrant = IF, grant IF when lastGrant = D. This alternates, so neither requester starves.
  - lastGrant updates on every grant.
- memReq = 1 exactly while state != IDLE, registered. memAddr, memWe and memWData stay constant for the whole transaction.
- FETCH or DATA with memAck = 1:
  - Return to IDLE; memReq drops the next cycle.
  - FETCH: capture memRData into ifData; pulse ifValid for one cycle, unless the transaction is cancelled.
  - DATA: capture memRData into dRData for loads only; pulse dValid for both loads and stores.
- No new grant occurs in the ack cycle; the earliest next grant is the cycle after returning to IDLE.
- Minimum latency: request seen at edge 0, memReq high in cycle 1, memAck in cycle 1, valid high in cycle 2.
- Fetch cancel:
  - ifFlush high during FETCH, or in the ack cycle, sets a cancel flag.
  - The transaction runs to memAck; ifData is not updated and ifValid is not pulsed. The cancel flag clears on return to IDLE.
  - Memory is never aborted mid-transaction.
  - ifFlush in IDLE blocks an IF grant that cycle.
- ifFlush has no effect on D transactions.
- Stalls (combinational):
  - stallIf = ifReq & ~ifValid.
  - stallMem = dReq & ~dValid.
  - Both drop in the valid-pulse cycle so the stage advances.
- memAck while IDLE is ignored and has no effect on outputs.
- Reset asserted mid-transaction: the block returns to IDLE immediately and memReq drops asynchronously. Memory must tolerate an abandoned request.
- Requesters must not change address or data while their request is high. The arbiter has already latched them, so changes are harmless but unsupported.

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_DATA = 2'd2.
  - Grant encoding constants GNT_IF = 1'b0, GNT_D = 1'b1.
  - Default ADDR_W and DATA_W.
- No sub-module needed; single FSM plus datapath registers.

Test Plan:
- Reset low for 2 cycles, then release → all outputs 0, state IDLE, memReq = 0.
- Fetch only: ifReq = 1, ifAddr = 0x40, memAck after 3 cycles with memRData = 0x8C220004 → memAddr = 0x40, memWe = 0; ifValid pulses once with ifData = 0x8C220004; stallIf high until that cycle.
- Simultaneous ifReq with ifAddr = 0x44 and load dReq with dAddr = 0x100, after an IF grant → D granted first, dRData = memRData and dValid pulse; then IF granted; next tie goes to D.
- Store: dReq = 1, dWe = 1, dAddr = 0x200, dWData = 0xDEADBEEF, ack after 1 cycle → memWe = 1, memWData = 0xDEADBEEF; dValid pulses; dRData unchanged.
- ifFlush pulse in cycle 2 of a fetch to 0x48, ack in cycle 4 → no ifValid, ifData unchanged, state IDLE afterwards.
- reset low mid-DATA transaction → memReq = 0 in the same cycle; no dValid; clean fetch succeeds after release.
